// File: rtl/seq_mul_pkg.sv
// Shared definitions for the req/ack sequential multiplier pair.
// Holds the FSM state encoding and the default operand/product widths.
package seq_mul_pkg;

  localparam int DW_DEFAULT = 4;
  localparam int PW_DEFAULT = 2 * DW_DEFAULT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic int prod_width(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/seq_mul_req_timeout_cnt.sv
// Cycle counter bounding how long a request may wait for its ack.
// expired is combinational so the FSM can abort in the same cycle it fires.
module req_timeout_cnt
  import seq_mul_pkg::*;
#(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/seq_mul_req.sv
// Initiator side of the req/ack multiplier handshake: takes operand pairs from a host,
// issues them as a level request, and returns the product (or a timeout error) to the host.
module seq_mul_req
  import seq_mul_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_op1,
  input  logic [DW-1:0]   in_op2,
  output logic            req,
  output logic [2*DW-1:0] req_data,
  input  logic            ack,
  input  logic [2*DW-1:0] ack_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_res,
  output logic            out_err,
  output logic            busy,
  output logic            spur_ack
);

  localparam int PW = prod_width(DW);

  state_e state;
  state_e state_nxt;
  logic   accept;
  logic   expired;

  assign accept = (state == ST_IDLE) && in_valid;

  req_timeout_cnt #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (state == ST_REQ),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // An ack in the timeout cycle still counts as a completed transaction.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = ST_REQ;
      ST_REQ:  if (ack || expired) state_nxt = ST_RESP;
      ST_RESP: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode straight from the state register, so reset drops req at once.
  assign req       = (state == ST_REQ);
  assign out_valid = (state == ST_RESP);
  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_data <= '0;
      out_res  <= '0;
      out_err  <= 1'b0;
      spur_ack <= 1'b0;
    end else begin
      if (accept) begin
        req_data <= {in_op1, in_op2};
      end
      if (state == ST_REQ) begin
        if (ack) begin
          out_res <= ack_data[PW-1:0];
          out_err <= 1'b0;
        end else if (expired) begin
          out_res <= '0;
          out_err <= 1'b1;
        end
      end
      if (ack && (state != ST_REQ)) begin
        spur_ack <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_mul_req.sv
// Self-checking bench for seq_mul_req: a responder acks after a chosen number of req cycles,
// and expected results come from plain multiplication and the timeout rule.
module tb_seq_mul_req;

  localparam int DW      = 4;
  localparam int PW      = 2 * DW;
  localparam int TO_W    = 8;
  localparam int TIMEOUT = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_op1;
  logic [DW-1:0] in_op2;
  logic          req;
  logic [PW-1:0] req_data;
  logic          ack;
  logic [PW-1:0] ack_data;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_res;
  logic          out_err;
  logic          busy;
  logic          spur_ack;

  int total = 0;
  int bad   = 0;
  bit spur_exp = 1'b0;

  always #5 clk = ~clk;

  seq_mul_req #(
    .DW      (DW),
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op1    (in_op1),
    .in_op2    (in_op2),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .ack_data  (ack_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_err   (out_err),
    .busy      (busy),
    .spur_ack  (spur_ack)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full host transaction; n_ack is the req cycle (1-based) carrying the ack, 0 = never.
  task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input int n_ack, input int hold, input bit late_ack);
    int            high;
    bit            stable;
    bit            held_ok;
    bit            exp_err;
    logic [PW-1:0] prod;
    logic [PW-1:0] exp_res;

    prod    = PW'(int'(a) * int'(b));
    exp_err = !(n_ack >= 1 && n_ack <= TIMEOUT);
    exp_res = exp_err ? '0 : prod;

    checkOutput("idle_req_low", req, 0);
    checkOutput("idle_in_ready", in_ready, 1);

    in_valid = 1'b1;
    in_op1   = a;
    in_op2   = b;
    tick;
    in_valid = 1'b0;
    in_op1   = DW'($urandom);
    in_op2   = DW'($urandom);

    high   = 0;
    stable = 1'b1;
    while (req === 1'b1 && high < TIMEOUT + 10) begin
      high++;
      if (req_data !== {a, b} || in_ready !== 1'b0) stable = 1'b0;
      ack      = (high == n_ack);
      ack_data = ack ? prod : PW'($urandom);
      tick;
    end
    ack = 1'b0;

    checkOutput("req_high_cycles", high, exp_err ? TIMEOUT : n_ack);
    checkOutput("req_data_stable", stable, 1);
    checkOutput("resp_out_valid", out_valid, 1);
    checkOutput("resp_out_res", out_res, exp_res);
    checkOutput("resp_out_err", out_err, exp_err);

    held_ok   = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_op1   = ~a;
      in_op2   = ~b;
      ack      = late_ack && (i == 0);
      ack_data = 8'hA5;
      tick;
      if (out_valid !== 1'b1 || out_res !== exp_res || out_err !== exp_err ||
          in_ready !== 1'b0 || req !== 1'b0) held_ok = 1'b0;
    end
    ack = 1'b0;
    if (late_ack && hold > 0) spur_exp = 1'b1;
    if (hold > 0) checkOutput("resp_hold", held_ok, 1);

    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    checkOutput("idle_after_resp", {busy, out_valid, req, in_ready}, 4'b0001);
    checkOutput("req_data_kept", req_data, {a, b});
    checkOutput("spur_ack", spur_ack, spur_exp);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op1    = '0;
    in_op2    = '0;
    ack       = 1'b0;
    ack_data  = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("rst_req", req, 0);
    checkOutput("rst_req_data", req_data, 0);
    checkOutput("rst_out", {out_valid, out_err, spur_ack, busy, in_ready}, 5'b00001);
    checkOutput("rst_out_res", out_res, 0);
    rst = 1'b0;
    tick;
    checkOutput("post_rst_idle", {busy, in_ready}, 2'b01);

    $display("[TB] basic 3*5");
    applyStimulus(4'd3, 4'd5, 4, 0, 1'b0);

    $display("[TB] back-to-back");
    applyStimulus(4'd15, 4'd15, 3, 0, 1'b0);
    applyStimulus(4'd0, 4'd9, 2, 0, 1'b0);

    $display("[TB] timeout with late ack");
    applyStimulus(4'd7, 4'd6, 0, 2, 1'b1);

    $display("[TB] host stall");
    applyStimulus(4'd9, 4'd7, 5, 10, 1'b0);

    $display("[TB] ack near and at timeout");
    applyStimulus(4'd5, 4'd6, TIMEOUT - 1, 1, 1'b0);
    applyStimulus(4'd11, 4'd13, TIMEOUT, 1, 1'b0);

    $display("[TB] random transactions");
    repeat (12) begin
      applyStimulus(DW'($urandom), DW'($urandom), int'($urandom_range(1, 8)),
                    int'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] reset during request");
    in_valid = 1'b1;
    in_op1   = 4'd6;
    in_op2   = 4'd7;
    tick;
    in_valid = 1'b0;
    tick;
    checkOutput("pre_rst_req", req, 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_req", req, 0);
    checkOutput("async_rst_flags", {out_valid, out_err, spur_ack, busy, in_ready}, 5'b00001);
    checkOutput("async_rst_data", {req_data, out_res}, 0);
    spur_exp = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    ack      = 1'b1;
    ack_data = 8'h2A;
    tick;
    ack = 1'b0;
    spur_exp = 1'b1;
    checkOutput("post_rst_ack_spur", spur_ack, 1);
    checkOutput("post_rst_ack_state", {busy, out_valid, req, in_ready}, 4'b0001);
    checkOutput("post_rst_ack_res", out_res, 0);

    applyStimulus(4'd2, 4'd3, 1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
